uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 18 +
 rtl/uart_rx_param.sv | 148 ++++++++++++++
 tb/tb_uart_rx_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the parameterized UART receiver.
// The majority-vote sampling option is enabled by defining UART_RX_MAJORITY_EN.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ff <= 2'b11;
    else         ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: start-edge detect, mid-bit sampling, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around the mid-bit point.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 219,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_data,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW   = 16;
  localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_CNT = HALF + 1;
`else
  localparam int DEC_CNT = HALF;
`endif

  logic                 rxs, rxs_d;
  rx_state_e            state;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, perr_acc, ferr_acc;
  logic                 at_dec, bit_val;

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx_data),
    .q      (rxs)
  );

  assign at_dec = (timer == TW'(DEC_CNT));

`ifdef UART_RX_MAJORITY_EN
  logic s_early, s_mid;
  // Third vote is the live sample, so the decision lands on the third sample cycle.
  assign bit_val = maj3(s_early, s_mid, rxs);
`else
  assign bit_val = rxs;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      rxs_d      <= 1'b1;
      timer      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s_early    <= 1'b1;
      s_mid      <= 1'b1;
`endif
    end else begin
      rxs_d      <= rxs;
      data_valid <= 1'b0;
      // Timer free-runs modulo one bit period, so every later sample stays mid-bit.
      if (state != ST_IDLE)
        timer <= (timer == TW'(CLKS_PER_BIT - 1)) ? '0 : timer + 1'b1;
`ifdef UART_RX_MAJORITY_EN
      if (timer == TW'(HALF - 1)) s_early <= rxs;
      if (timer == TW'(HALF))     s_mid   <= rxs;
`endif
      case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            state <= ST_START;
            timer <= '0;
          end
        end
        ST_START: begin
          if (at_dec) begin
            if (bit_val) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              par_acc  <= 1'b0;
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (at_dec) begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ bit_val;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              state    <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_dec) begin
            perr_acc <= (PARITY == PAR_ODD) ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (at_dec) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              data       <= shreg;
              parity_err <= perr_acc;
              frame_err  <= ferr_acc | ~bit_val;
              data_valid <= 1'b1;
              // A low stop bit may be a break: wait for the line to return high.
              state      <= (ferr_acc | ~bit_val) ? ST_WAIT_IDLE : ST_IDLE;
            end else begin
              ferr_acc <= ~bit_val;
              stop_idx <= 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 instance (A) and 7E1 instance (B), scoreboard-checked.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB  = 219;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = HALF + 5;
`else
  localparam int LAT = HALF + 4;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       dv_a, perr_a, ferr_a, busy_a;
  logic [7:0] data_a;
  logic       dv_b, perr_b, ferr_b, busy_b;
  logic [6:0] data_b;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .resetn(resetn), .rx_data(rx_a), .data_valid(dv_a),
    .data(data_a), .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .resetn(resetn), .rx_data(rx_b), .data_valid(dv_b),
    .data(data_b), .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  always #19.84 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    bit         sel;
    logic [8:0] d;
    int         nbits;
    bit         par_en;
    logic       pb;
    logic [8:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  int   stop_t_a = 0, stop_t_b = 0;
  logic pdv_a = 1'b0, pdv_b = 1'b0;
  vec_t vt[7];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitors: every pulse pops one expectation.
  always @(negedge clk) begin
    if (resetn && dv_a) begin
      chk("a_dv_width", pdv_a, 0);
      if (q_a.size() == 0) chk("a_unexpected_dv", dv_a, 0);
      else begin
        e_a = q_a.pop_front();
        chk("a_data", data_a, e_a.data[7:0]);
        chk("a_parity_err", perr_a, e_a.perr);
        chk("a_frame_err", ferr_a, e_a.ferr);
        chk("a_latency_in_range", ((cyc - stop_t_a) >= LAT - 1) && ((cyc - stop_t_a) <= LAT + 1), 1);
      end
    end
    pdv_a <= dv_a;
  end

  always @(negedge clk) begin
    if (resetn && dv_b) begin
      chk("b_dv_width", pdv_b, 0);
      if (q_b.size() == 0) chk("b_unexpected_dv", dv_b, 0);
      else begin
        e_b = q_b.pop_front();
        chk("b_data", data_b, e_b.data[6:0]);
        chk("b_parity_err", perr_b, e_b.perr);
        chk("b_frame_err", ferr_b, e_b.ferr);
        chk("b_latency_in_range", ((cyc - stop_t_b) >= LAT - 1) && ((cyc - stop_t_b) <= LAT + 1), 1);
      end
    end
    pdv_b <= dv_b;
  end

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // One bit period on the line; optional one-cycle inverted spike at offset 'spike'.
  task automatic drive_bit(input bit sel, input logic v, input int spike, input bit mark);
    @(negedge clk);
    set_rx(sel, v);
    if (mark) begin
      if (sel) stop_t_b = cyc;
      else     stop_t_a = cyc;
    end
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      set_rx(sel, (i == spike) ? ~v : v);
    end
  endtask

  // stop_low = 0 sends a good stop bit; otherwise holds the line low that many bit times.
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nbits, input bit par_en,
                            input logic pb, input int stop_low, input int spike);
    drive_bit(sel, 1'b0, spike, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], spike, 1'b0);
    if (par_en) drive_bit(sel, pb, spike, 1'b0);
    if (stop_low == 0) drive_bit(sel, 1'b1, spike, 1'b1);
    else for (int i = 0; i < stop_low; i++) drive_bit(sel, 1'b0, -1, i == 0);
  endtask

  initial begin
    #3600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 9'h055, 8, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
    vt[1] = '{1'b0, 9'h0A3, 8, 1'b0, 1'b0, 9'h0A3, 1'b0, 1'b0};
    vt[2] = '{1'b0, 9'h000, 8, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[3] = '{1'b0, 9'h0FF, 8, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0};
    vt[4] = '{1'b1, 9'h041, 7, 1'b1, 1'b0, 9'h041, 1'b0, 1'b0};
    vt[5] = '{1'b1, 9'h041, 7, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
    vt[6] = '{1'b1, 9'h07F, 7, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0};

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_data_a", data_a, 0);
    chk("rst_dv_a", dv_a, 0);
    chk("rst_perr_a", perr_a, 0);
    chk("rst_ferr_a", ferr_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_data_b", data_b, 0);
    chk("rst_busy_b", busy_b, 0);
    resetn = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("idle_busy_a", busy_a, 0);

    // Table: back-to-back frames on each instance
    for (int v = 0; v < 7; v++) begin
      if (vt[v].sel) q_b.push_back('{vt[v].exp_d, vt[v].exp_perr, vt[v].exp_ferr});
      else           q_a.push_back('{vt[v].exp_d, vt[v].exp_perr, vt[v].exp_ferr});
      send_frame(vt[v].sel, vt[v].d, vt[v].nbits, vt[v].par_en, vt[v].pb, 0, -1);
    end

    // Break: stop held low for three bit times, then clean frame
    q_a.push_back('{9'h0A5, 1'b0, 1'b1});
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 2, -1);
    chk("break_busy_line_low", busy_a, 1);
    chk("break_hold_data", data_a, 8'hA5);
    chk("break_hold_ferr", ferr_a, 1);
    drive_bit(1'b0, 1'b0, -1, 1'b0);
    drive_bit(1'b0, 1'b1, -1, 1'b0);
    chk("break_busy_after_high", busy_a, 0);
    q_a.push_back('{9'h03C, 1'b0, 1'b0});
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 0, -1);

    // Glitch on idle line: false start
    @(negedge clk);
    rx_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_busy_high", busy_a, 1);
    repeat (10) @(negedge clk);
    rx_a = 1'b1;
    repeat (110) @(negedge clk);
    chk("glitch_busy_low", busy_a, 0);
    chk("glitch_hold_data", data_a, 8'h3C);

    // Reset mid-DATA of 0x96
    drive_bit(1'b0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, (8'h96 >> i) & 8'h01, -1, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    rx_a   = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data_a", data_a, 0);
    chk("midrst_busy_a", busy_a, 0);
    chk("midrst_dv_a", dv_a, 0);
    resetn = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("postrst_busy_a", busy_a, 0);
    q_a.push_back('{9'h069, 1'b0, 1'b0});
    send_frame(1'b0, 9'h069, 8, 1'b0, 1'b0, 0, -1);

`ifdef UART_RX_MAJORITY_EN
    // Inverted one-cycle spike at every mid-bit is out-voted
    q_a.push_back('{9'h0C5, 1'b0, 1'b0});
    send_frame(1'b0, 9'h0C5, 8, 1'b0, 1'b0, 0, HALF + 1);
`endif

    repeat (CPB) @(negedge clk);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
